// File: rtl/breath_led_cfg_master_if.sv
// AXI4-Lite master bus bundle for breath_led_cfg_master; master drives AW/W/AR and B/R ready,
// slave drives the ready/response side.
interface breath_led_cfg_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] M_AXI_AWADDR;
    logic              M_AXI_AWVALID;
    logic              M_AXI_AWREADY;
    logic [DATA_W-1:0] M_AXI_WDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_WVALID;
    logic              M_AXI_WREADY;
    logic [1:0]        M_AXI_BRESP;
    logic              M_AXI_BVALID;
    logic              M_AXI_BREADY;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [DATA_W-1:0] M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
               M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
               M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
               M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
               M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );
endinterface

// File: rtl/breath_led_cfg_master.sv
// AXI4-Lite master writing an init table to BASE_ADDR+4*i on start; 2 cycles/register with a zero-wait
// slave, waits on slave ready/valid up to TIMEOUT_CYCLES. BREATH_LED_CFG_READBACK_EN adds a read-compare pass.
module breath_led_cfg_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter logic [C_M_AXI_DATA_WIDTH*NUM_REGS-1:0] INIT_DATA = {32'h4, 32'h3, 32'h2, 32'h1},
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] err_idx,
    breath_led_cfg_master_if.master m_axi
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [3:0]  LAST_IDX = 4'(NUM_REGS - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RD, S_RRESP, S_FIN} state_t;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d, idx_nxt;
    logic [15:0]    tmo_q, tmo_d;
    logic           abort_q, abort_d;
    logic           awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [AW-1:0]  awaddr_q, awaddr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           done_q, done_d, err_q, err_d;
    logic [3:0]     err_idx_q, err_idx_d;
    logic           tmo_hit;

    // Padded to 16 entries so a 4-bit index never selects outside the table.
    logic [DW-1:0] tbl [16];
    for (genvar gi = 0; gi < 16; gi++) begin : g_tbl
        if (gi < NUM_REGS) begin : g_used
            assign tbl[gi] = INIT_DATA[DW*gi +: DW];
        end else begin : g_pad
            assign tbl[gi] = '0;
        end
    end

    function automatic logic [AW-1:0] reg_addr(input logic [3:0] i);
        return BASE_ADDR + AW'({i, 2'b00});
    endfunction

    assign idx_nxt = idx_q + 4'd1;
    assign tmo_hit = (tmo_q == TMO_LAST);

`ifdef BREATH_LED_CFG_READBACK_EN
    logic          arvalid_q, arvalid_d, rready_q, rready_d;
    logic [AW-1:0] araddr_q, araddr_d;
`else
    logic unused_rd;
    assign unused_rd = ^{m_axi.M_AXI_ARREADY, m_axi.M_AXI_RDATA, m_axi.M_AXI_RRESP, m_axi.M_AXI_RVALID};
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q + 16'd1;
        abort_d   = abort_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        done_d    = done_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
`ifdef BREATH_LED_CFG_READBACK_EN
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        araddr_d  = araddr_q;
`endif
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (start) begin
                    state_d   = S_WR;
                    idx_d     = '0;
                    abort_d   = 1'b0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = reg_addr(4'd0);
                    wdata_d   = tbl[0];
                end
            end
            S_WR: begin
                // AW and W complete independently; a valid already dropped counts as done.
                if (m_axi.M_AXI_AWREADY) awvalid_d = 1'b0;
                if (m_axi.M_AXI_WREADY)  wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi.M_AXI_AWREADY) && (!wvalid_q || m_axi.M_AXI_WREADY)) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                    tmo_d    = '0;
                end else if (tmo_hit) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    abort_d   = 1'b1;
                    state_d   = S_FIN;
                    tmo_d     = '0;
                end
            end
            S_WRESP: begin
                if (m_axi.M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    tmo_d    = '0;
                    if (m_axi.M_AXI_BRESP != 2'b00) begin
                        abort_d = 1'b1;
                        state_d = S_FIN;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d     = idx_nxt;
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = reg_addr(idx_nxt);
                        wdata_d   = tbl[idx_nxt];
                    end else begin
`ifdef BREATH_LED_CFG_READBACK_EN
                        idx_d     = '0;
                        state_d   = S_RD;
                        arvalid_d = 1'b1;
                        araddr_d  = reg_addr(4'd0);
`else
                        state_d   = S_FIN;
`endif
                    end
                end else if (tmo_hit) begin
                    bready_d = 1'b0;
                    abort_d  = 1'b1;
                    state_d  = S_FIN;
                    tmo_d    = '0;
                end
            end
`ifdef BREATH_LED_CFG_READBACK_EN
            S_RD: begin
                if (m_axi.M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RRESP;
                    tmo_d     = '0;
                end else if (tmo_hit) begin
                    arvalid_d = 1'b0;
                    abort_d   = 1'b1;
                    state_d   = S_FIN;
                    tmo_d     = '0;
                end
            end
            S_RRESP: begin
                if (m_axi.M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    tmo_d    = '0;
                    if (m_axi.M_AXI_RRESP != 2'b00 || m_axi.M_AXI_RDATA != tbl[idx_q]) begin
                        abort_d = 1'b1;
                        state_d = S_FIN;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d     = idx_nxt;
                        state_d   = S_RD;
                        arvalid_d = 1'b1;
                        araddr_d  = reg_addr(idx_nxt);
                    end else begin
                        state_d = S_FIN;
                    end
                end else if (tmo_hit) begin
                    rready_d = 1'b0;
                    abort_d  = 1'b1;
                    state_d  = S_FIN;
                    tmo_d    = '0;
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
                tmo_d   = '0;
                abort_d = 1'b0;
                if (abort_q) begin
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            abort_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
`ifdef BREATH_LED_CFG_READBACK_EN
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            abort_q   <= abort_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
`ifdef BREATH_LED_CFG_READBACK_EN
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done    = done_q;
    assign err     = err_q;
    assign err_idx = err_idx_q;

    assign m_axi.M_AXI_AWADDR  = awaddr_q;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = 4'hF;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
`ifdef BREATH_LED_CFG_READBACK_EN
    assign m_axi.M_AXI_ARADDR  = araddr_q;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;
`else
    assign m_axi.M_AXI_ARADDR  = '0;
    assign m_axi.M_AXI_ARVALID = 1'b0;
    assign m_axi.M_AXI_RREADY  = 1'b0;
`endif
endmodule

// File: tb/tb_breath_led_cfg_master.sv
// Directed bench for breath_led_cfg_master: reactive AXI4-Lite slave with scoreboard of expected accesses.
module tb_breath_led_cfg_master;
    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, err;
    logic [3:0] err_idx;

    breath_led_cfg_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    breath_led_cfg_master dut (
        .ACLK    (aclk),
        .ARESETN (aresetn),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_idx (err_idx),
        .m_axi   (axi)
    );

    always #5 aclk = ~aclk;

`ifdef BREATH_LED_CFG_READBACK_EN
    localparam int DONE_EDGE = 17;
`else
    localparam int DONE_EDGE = 9;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    logic [31:0] exp_rd_q[$];

    int          aw_delay = 0;
    int          slverr_idx = -1;
    bit          bvalid_never = 1'b0;
    logic [31:0] bad_rd_addr = 32'hFFFF_FFFF;

    bit          have_aw, have_w, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] cap_addr, cap_data, pre_awaddr, pre_wdata, pre_araddr;
    int          wr_count = 0;
    int          aw_wait = 0;
    logic [31:0] mem [16];
    wr_t         e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave samples pre-edge handshakes at the rising edge and updates its outputs 1ns later.
    always @(posedge aclk) begin
        aw_hs      = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
        w_hs       = axi.M_AXI_WVALID && axi.M_AXI_WREADY;
        b_hs       = axi.M_AXI_BVALID && axi.M_AXI_BREADY;
        ar_hs      = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
        r_hs       = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
        pre_awaddr = axi.M_AXI_AWADDR;
        pre_wdata  = axi.M_AXI_WDATA;
        pre_araddr = axi.M_AXI_ARADDR;
        #1;
        if (!aresetn) begin
            have_aw = 1'b0;
            have_w  = 1'b0;
            aw_wait = 0;
            axi.M_AXI_BVALID  = 1'b0;
            axi.M_AXI_RVALID  = 1'b0;
            axi.M_AXI_AWREADY = (aw_delay == 0);
        end else begin
            if (b_hs) axi.M_AXI_BVALID = 1'b0;
            if (r_hs) axi.M_AXI_RVALID = 1'b0;
            if (aw_hs) begin have_aw = 1'b1; cap_addr = pre_awaddr; end
            if (w_hs)  begin have_w  = 1'b1; cap_data = pre_wdata;  end
            if (have_aw && have_w) begin
                if (exp_q.size() == 0) begin
                    check("sb_write_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", cap_addr, e.addr);
                    check("wr_data", cap_data, e.data);
                end
                mem[cap_addr[5:2]] = cap_data;
                if (!bvalid_never) begin
                    axi.M_AXI_BVALID = 1'b1;
                    axi.M_AXI_BRESP  = (wr_count == slverr_idx) ? 2'b10 : 2'b00;
                end
                wr_count++;
                have_aw = 1'b0;
                have_w  = 1'b0;
            end
            if (aw_delay == 0) begin
                axi.M_AXI_AWREADY = 1'b1;
            end else if (aw_hs) begin
                aw_wait = 0;
                axi.M_AXI_AWREADY = 1'b0;
            end else if (axi.M_AXI_AWVALID) begin
                aw_wait++;
                axi.M_AXI_AWREADY = (aw_wait >= aw_delay);
            end
            if (ar_hs) begin
                if (exp_rd_q.size() == 0) check("sb_read_expected", 32'(exp_rd_q.size()), 32'd1);
                else check("rd_addr", pre_araddr, exp_rd_q.pop_front());
                axi.M_AXI_RVALID = 1'b1;
                axi.M_AXI_RRESP  = 2'b00;
                axi.M_AXI_RDATA  = (pre_araddr == bad_rd_addr) ? 32'h7 : mem[pre_araddr[5:2]];
            end
        end
    end

    task automatic push_seq();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{addr: 32'(4 * i), data: 32'(i + 1)});
`ifdef BREATH_LED_CFG_READBACK_EN
            exp_rd_q.push_back(32'(4 * i));
`endif
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int max_cycles);
        for (int i = 0; i < max_cycles && !(done || err); i++) begin
            @(posedge aclk); #1;
        end
        check("sequence_ended", 32'(done | err), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, busy=%0b", busy);
        $fatal(1, "watchdog");
    end

    initial begin
        axi.M_AXI_AWREADY = 1'b1;
        axi.M_AXI_WREADY  = 1'b1;
        axi.M_AXI_BVALID  = 1'b0;
        axi.M_AXI_BRESP   = 2'b00;
        axi.M_AXI_ARREADY = 1'b1;
        axi.M_AXI_RVALID  = 1'b0;
        axi.M_AXI_RDATA   = '0;
        axi.M_AXI_RRESP   = 2'b00;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        check("rst_err_idx", 32'(err_idx), 32'd0);
        check("rst_valids_readies", {27'd0, axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY,
                                     axi.M_AXI_ARVALID, axi.M_AXI_RREADY}, 32'd0);
        check("rst_awaddr", axi.M_AXI_AWADDR, 32'd0);
        check("rst_wdata", axi.M_AXI_WDATA, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Zero-wait slave: exact completion edge.
        push_seq();
        pulse_start();
        check("t1_first_aw", {31'd0, axi.M_AXI_AWVALID & axi.M_AXI_WVALID}, 32'd1);
        check("t1_first_addr", axi.M_AXI_AWADDR, 32'h0);
        check("t1_first_data", axi.M_AXI_WDATA, 32'h1);
        check("t1_wstrb", 32'(axi.M_AXI_WSTRB), 32'hF);
        @(posedge aclk); #1;
        check("t1_busy", 32'(busy), 32'd1);
        repeat (DONE_EDGE - 2) @(posedge aclk);
        #1;
        check("t1_done_before_edge", 32'(done), 32'd0);
        @(posedge aclk); #1;
        check("t1_done_at_edge", 32'(done), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_sb_drained", 32'(exp_q.size() + exp_rd_q.size()), 32'd0);
        check("t1_araddr_idle", axi.M_AXI_ARADDR, 32'(DONE_EDGE == 17 ? 32'hC : 32'h0));

        // AWREADY delayed 3 cycles; W completes first; a second start mid-run is ignored.
        aw_delay = 3;
        push_seq();
        pulse_start();
        @(posedge aclk); #1;
        check("t2_wvalid_dropped", 32'(axi.M_AXI_WVALID), 32'd0);
        check("t2_awvalid_held", 32'(axi.M_AXI_AWVALID), 32'd1);
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        check("t2_awvalid_held2", 32'(axi.M_AXI_AWVALID), 32'd1);
        check("t2_awaddr_stable", axi.M_AXI_AWADDR, 32'h0);
        check("t2_wdata_stable", axi.M_AXI_WDATA, 32'h1);
        wait_end(300);
        check("t2_done_err", {30'd0, done, err}, 32'd2);
        check("t2_sb_drained", 32'(exp_q.size() + exp_rd_q.size()), 32'd0);
        aw_delay = 0;
        @(posedge aclk); #1;

        // SLVERR on the third write.
        slverr_idx = 2;
        wr_count = 0;
        push_seq();
        pulse_start();
        wait_end(300);
        check("t3_err", 32'(err), 32'd1);
        check("t3_err_idx", 32'(err_idx), 32'd2);
        check("t3_done_busy", {30'd0, done, busy}, 32'd0);
        repeat (5) @(posedge aclk);
        #1;
        check("t3_write_count", 32'(wr_count), 32'd3);
        check("t3_no_more_aw", 32'(axi.M_AXI_AWVALID), 32'd0);
        check("t3_sb_left", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        exp_rd_q.delete();
        slverr_idx = -1;

        // BVALID never returned: timeout after 1024 cycles in WRESP.
        bvalid_never = 1'b1;
        push_seq();
        pulse_start();
        repeat (1024) @(posedge aclk);
        #1;
        check("t4_bready_waiting", {30'd0, axi.M_AXI_BREADY, err}, 32'd2);
        @(posedge aclk); #1;
        check("t4_bready_dropped", {30'd0, axi.M_AXI_BREADY, err}, 32'd0);
        @(posedge aclk); #1;
        check("t4_err", 32'(err), 32'd1);
        check("t4_err_idx", 32'(err_idx), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        exp_q.delete();
        exp_rd_q.delete();
        bvalid_never = 1'b0;

`ifdef BREATH_LED_CFG_READBACK_EN
        // Readback mismatch at 0x8.
        bad_rd_addr = 32'h8;
        push_seq();
        pulse_start();
        wait_end(300);
        check("t5_err", 32'(err), 32'd1);
        check("t5_err_idx", 32'(err_idx), 32'd2);
        check("t5_rd_left", 32'(exp_rd_q.size()), 32'd1);
        exp_rd_q.delete();
        bad_rd_addr = 32'hFFFF_FFFF;
`endif

        // Reset during the second write, then a clean restart.
        push_seq();
        pulse_start();
        repeat (2) @(posedge aclk);
        #1;
        check("t6_second_addr", axi.M_AXI_AWADDR, 32'h4);
        aresetn = 1'b0;
        #1;
        check("t6_rst_valids", {29'd0, axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY}, 32'd0);
        check("t6_rst_status", {28'd0, busy, done, err, 1'b0} | 32'(err_idx), 32'd0);
        check("t6_rst_addr_data", axi.M_AXI_AWADDR | axi.M_AXI_WDATA, 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_q.delete();
        exp_rd_q.delete();
        @(posedge aclk); #1;
        push_seq();
        pulse_start();
        wait_end(300);
        check("t6_restart_done_err", {30'd0, done, err}, 32'd2);
        check("t6_sb_drained", 32'(exp_q.size() + exp_rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
